// File: rtl/mont_pkg.sv
// Shared constants and FSM state type for the Montgomery reduction scheduler.
// Optional range checking is enabled in the top level with MONT_SCHED_RANGE_CHK_EN.
package mont_pkg;

    localparam int Q_DEFAULT = 3329;
    localparam int R_BITS    = 12;
    localparam int X_W       = 26;
    localparam int Y_W       = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mont_tag_pipe.sv
// Fixed-depth pipe that carries each issued operation's requester tag in step
// with the shared reducer latency.
module mont_tag_pipe #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             drained
);

    logic [DEPTH-1:0] vld;
    logic [TAG_W-1:0] tag [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag[0] <= in_tag;
        for (int i = 1; i < DEPTH; i++) begin
            tag[i] <= tag[i-1];
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];
    assign busy      = |vld;

    // Empty after the next edge: only the final stage (if anything) is occupied.
    always_comb begin
        drained = !in_valid;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (vld[i]) drained = 1'b0;
        end
    end

endmodule

// File: rtl/mont_reduce_sched.sv
// Round-robin scheduler sharing one fixed-latency Montgomery reducer among
// NUM_REQ requesters; define MONT_SCHED_RANGE_CHK_EN to flag operands >= Q*2^12.
module mont_reduce_sched
    import mont_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 4,
    parameter int Q       = Q_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   red_en,
    output logic [X_W-1:0]         red_x,
    input  logic [Y_W-1:0]         red_y,
    input  logic                   red_valid,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [R_BITS-1:0]      rsp_y,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [1:0]             err,
    output state_t                 dbg_state
);

    // Valid/ready: a requester holds req_valid and its req_x slice stable until
    // a cycle where req_valid[i] && req_ready[i]; that cycle is the transfer.
    localparam int TW = $clog2(NUM_REQ);
    localparam int GW = $clog2(LAT + 1);
    localparam logic [Y_W-1:0] Q_Y = Y_W'(Q);

    state_t          state;
    logic [TW-1:0]   ptr;
    logic [TW-1:0]   gnt_idx;
    logic [TW-1:0]   issue_tag;
    logic [TW-1:0]   out_tag;
    logic            gnt_any;
    logic            grant_ok;
    logic            xfer;
    logic            out_valid;
    logic            pipe_busy;
    logic            pipe_drained;
    logic [X_W-1:0]  x_sel;
    logic [R_BITS-1:0] y_corr;
    logic            err_sync;
    logic            err_range;
    logic [GW-1:0]   guard;

    always_comb begin
        logic [TW:0] sum;
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (TW+1)'(k);
            if (sum >= (TW+1)'(NUM_REQ)) sum = sum - (TW+1)'(NUM_REQ);
            if (!gnt_any && req_valid[sum[TW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = sum[TW-1:0];
            end
        end
    end

    assign grant_ok = (state == ST_RUN) && !flush;
    assign xfer     = grant_ok && gnt_any;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == TW'(i)) x_sel = req_x[i*X_W +: X_W];
        end
    end

    always_comb begin
        y_corr = (red_y >= Q_Y) ? R_BITS'(red_y - Q_Y) : R_BITS'(red_y);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE:  if (!flush)      state <= ST_RUN;
                ST_RUN:   if (flush)       state <= ST_DRAIN;
                ST_DRAIN: if (pipe_drained) state <= ST_IDLE;
                default:                   state <= ST_IDLE;
            endcase
            if (xfer) ptr <= (gnt_idx == TW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // The guard hides red_valid strobes belonging to operations dropped by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_en    <= 1'b0;
            red_x     <= '0;
            issue_tag <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            err_sync  <= 1'b0;
            guard     <= GW'(LAT);
        end else begin
            red_en <= xfer;
            if (xfer) begin
                red_x     <= x_sel;
                issue_tag <= gnt_idx;
            end
            rsp_valid <= '0;
            if (out_valid && red_valid) begin
                rsp_valid[out_tag] <= 1'b1;
                rsp_y              <= y_corr;
            end
            if (guard != '0) guard <= guard - 1'b1;
            else if (out_valid != red_valid) err_sync <= 1'b1;
        end
    end

`ifdef MONT_SCHED_RANGE_CHK_EN
    localparam int unsigned X_LIMIT = Q << R_BITS;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_range <= 1'b0;
        end else if (xfer && (32'(x_sel) >= X_LIMIT)) begin
            err_range <= 1'b1;
        end
    end
`else
    assign err_range = 1'b0;
`endif

    mont_tag_pipe #(
        .DEPTH (LAT),
        .TAG_W (TW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (red_en),
        .in_tag    (issue_tag),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .busy      (pipe_busy),
        .drained   (pipe_drained)
    );

    assign flush_done = !rst_n || ((state == ST_IDLE) && !pipe_busy && !red_en);
    assign err        = {err_range, err_sync};
    assign dbg_state  = state;

endmodule
